reg_file_2r1w: RTL

- Architectural register file for the single-cycle datapath: 32 x 32-bit, two combinational read ports, one clocked write port.
- Sits directly downstream of the 5-bit destination-register select mux (rt/rd). That mux output drives inWriteAddr.
- After reset, a sequencer clears every register one per cycle, then raises outReady. The core stalls until outReady is high.

---
 rtl/reg_file_2r1w_pkg.sv | 15 +
 rtl/reg_file_2r1w_if.sv | 24 ++
 rtl/reg_file_2r1w_init_ctrl.sv | 48 ++++
 rtl/reg_file_2r1w.sv | 63 ++++++
 4 files changed

// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants and state encoding for the 32 x 32 architectural register file.
// Pure declarations, no logic.
package regfile_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO  = 5'd0;
    localparam logic [ADDR_W-1:0] INIT_LAST = 5'd31;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } rf_state_e;
endpackage

// File: rtl/reg_file_2r1w_if.sv
// Register-file access bundle: one write port, two read ports, ready indication.
// Core side drives addresses/write data; register file drives read data and ready.
interface reg_file_2r1w_if;
    import regfile_pkg::*;

    logic              inRegWrite;
    logic [ADDR_W-1:0] inWriteAddr;
    logic [DATA_W-1:0] inWriteData;
    logic [ADDR_W-1:0] inReadAddrA;
    logic [ADDR_W-1:0] inReadAddrB;
    logic [DATA_W-1:0] outReadDataA;
    logic [DATA_W-1:0] outReadDataB;
    logic              outReady;

    modport master (
        output inRegWrite, inWriteAddr, inWriteData, inReadAddrA, inReadAddrB,
        input  outReadDataA, outReadDataB, outReady
    );

    modport slave (
        input  inRegWrite, inWriteAddr, inWriteData, inReadAddrA, inReadAddrB,
        output outReadDataA, outReadDataB, outReady
    );
endinterface

// File: rtl/reg_file_2r1w_init_ctrl.sv
// Post-reset clear sequencer: walks addresses 1..31 one per cycle, then reports ready.
// Latency: ready rises on the 31st edge after reset release; no backpressure, free-running.
// Backpressure: none; the core is expected to stall on !ready.
module reg_file_init_ctrl
    import regfile_pkg::*;
(
    input  logic              inClk,
    input  logic              inReset,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            // Address 0 has no storage, so the walk starts at 1 and stops at the last register.
            if (cnt_q == INIT_LAST) begin
                state_d = READY;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end
        ready_d = (state_d == READY);
    end

    always_ff @(posedge inClk) begin
        if (inReset) begin
            state_q <= INIT;
            cnt_q   <= ADDR_W'(1);
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign clr_en   = (state_q == INIT);
    assign clr_addr = cnt_q;
    assign ready    = ready_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// 32 x 32-bit register file, two combinational read ports, one clocked write port, r0 reads zero.
// Latency: reads 0 cycles, writes visible after the edge; REGFILE_BYPASS_EN forwards same-cycle writes.
// Backpressure: none; outReady stays low during the post-reset clear and writes are dropped then.
module reg_file_2r1w
    import regfile_pkg::*;
(
    input  logic            inClk,
    input  logic            inReset,
    reg_file_2r1w_if.slave  bus
);

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    reg_file_init_ctrl u_init_ctrl (
        .inClk    (inClk),
        .inReset  (inReset),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    always_comb begin
        regs_d = regs_q;
        if (!inReset) begin
            if (clr_en) begin
                regs_d[clr_addr] = '0;
            end else if (ready && bus.inRegWrite && (bus.inWriteAddr != REG_ZERO)) begin
                regs_d[bus.inWriteAddr] = bus.inWriteData;
            end
        end
        regs_d[REG_ZERO] = '0;
    end

    // No reset on the array: the clear sequencer zeroes it before ready is raised.
    always_ff @(posedge inClk) begin
        regs_q <= regs_d;
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (ready && (bus.inReadAddrA != REG_ZERO)) rd_a = regs_q[bus.inReadAddrA];
        if (ready && (bus.inReadAddrB != REG_ZERO)) rd_b = regs_q[bus.inReadAddrB];
`ifdef REGFILE_BYPASS_EN
        if (ready && bus.inRegWrite && (bus.inWriteAddr != REG_ZERO)) begin
            if (bus.inWriteAddr == bus.inReadAddrA) rd_a = bus.inWriteData;
            if (bus.inWriteAddr == bus.inReadAddrB) rd_b = bus.inWriteData;
        end
`endif
    end

    assign bus.outReadDataA = rd_a;
    assign bus.outReadDataB = rd_b;
    assign bus.outReady     = ready;

endmodule
